// File: rtl/mem_bus_interface.sv
// rtl/mem_bus_interface.sv - strobe to req/ack bridge between the multicycle controller and external memory
//
// Purpose: turns one-cycle controller strobes (mld, mem_write, mout) into a
// registered req/ack handshake with a variable-latency memory. Holds MAR, WDR
// and MDR, and raises busy so the controller freezes until the access ends.
//
// Optional feature: define MEM_TIMEOUT_EN to abort accesses that receive no
// mem_ack within TIMEOUT wait cycles (reads then return all ones).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   addr_in, wdata_in   address / write data from the internal bus
//   mld, mem_write      start read / start write (one-cycle strobes)
//   mout                request MDR onto the internal bus
//   rdata_out           current MDR contents
//   bus_drive           MDR bus enable (mout gated by ~busy)
//   busy                stall to the controller
//   mem_req, mem_we     external request / write enable (registered)
//   mem_addr, mem_wdata external address (MAR) / write data (WDR)
//   mem_rdata, mem_ack  external read data / one-cycle completion
//   overlap_err         sticky: strobe received while busy or colliding
//   timeout_err         sticky: access aborted on timeout
module mem_bus_interface #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              mld,
    input  logic              mem_write,
    input  logic              mout,
    output logic [DATA_W-1:0] rdata_out,
    output logic              bus_drive,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              overlap_err,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] mar, mar_nx;
    logic [DATA_W-1:0] wdr, wdr_nx;
    logic [DATA_W-1:0] mdr, mdr_nx;
    logic              req, req_nx;
    logic              we, we_nx;
    logic              ovl, ovl_nx;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             tmo, tmo_nx;
    logic             expire;

    // cnt counts completed wait cycles; the TIMEOUT-th cycle without ack aborts.
    assign expire = (cnt == CNT_W'(TIMEOUT - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mar   <= '0;
            wdr   <= '0;
            mdr   <= '0;
            req   <= 1'b0;
            we    <= 1'b0;
            ovl   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt   <= '0;
            tmo   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            mar   <= mar_nx;
            wdr   <= wdr_nx;
            mdr   <= mdr_nx;
            req   <= req_nx;
            we    <= we_nx;
            ovl   <= ovl_nx;
`ifdef MEM_TIMEOUT_EN
            cnt   <= cnt_nx;
            tmo   <= tmo_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        mar_nx   = mar;
        wdr_nx   = wdr;
        mdr_nx   = mdr;
        req_nx   = req;
        we_nx    = we;
        ovl_nx   = ovl;
`ifdef MEM_TIMEOUT_EN
        cnt_nx   = cnt;
        tmo_nx   = tmo;
`endif
        case (state)
            IDLE: begin
`ifdef MEM_TIMEOUT_EN
                cnt_nx = '0;
`endif
                // Write has priority; a colliding read strobe is dropped and flagged.
                if (mem_write) begin
                    wdr_nx   = wdata_in;
                    mar_nx   = addr_in;
                    req_nx   = 1'b1;
                    we_nx    = 1'b1;
                    state_nx = WR_WAIT;
                    if (mld) ovl_nx = 1'b1;
                end else if (mld) begin
                    mar_nx   = addr_in;
                    req_nx   = 1'b1;
                    we_nx    = 1'b0;
                    state_nx = RD_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (mld || mem_write) ovl_nx = 1'b1;
                if (mem_ack) begin
                    if (state == RD_WAIT) mdr_nx = mem_rdata;
                    req_nx   = 1'b0;
                    we_nx    = 1'b0;
                    state_nx = IDLE;
`ifdef MEM_TIMEOUT_EN
                end else if (expire) begin
                    if (state == RD_WAIT) mdr_nx = {DATA_W{1'b1}};
                    req_nx   = 1'b0;
                    we_nx    = 1'b0;
                    tmo_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
`endif
                end
            end
            default: begin
                req_nx   = 1'b0;
                we_nx    = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    assign busy        = (state != IDLE);
    assign bus_drive   = mout & ~busy;
    assign rdata_out   = mdr;
    assign mem_req     = req;
    assign mem_we      = we;
    assign mem_addr    = mar;
    assign mem_wdata   = wdr;
    assign overlap_err = ovl;
`ifdef MEM_TIMEOUT_EN
    assign timeout_err = tmo;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_interface.sv
// tb/tb_mem_bus_interface.sv - directed self-checking bench for mem_bus_interface
module tb_mem_bus_interface;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] addr_in;
    logic [7:0]  wdata_in;
    logic        mld, mem_write, mout;
    logic [7:0]  rdata_out;
    logic        bus_drive, busy, mem_req, mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        overlap_err, timeout_err;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    mem_bus_interface #(.ADDR_W(12), .DATA_W(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .addr_in(addr_in), .wdata_in(wdata_in),
        .mld(mld), .mem_write(mem_write), .mout(mout),
        .rdata_out(rdata_out), .bus_drive(bus_drive), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .overlap_err(overlap_err), .timeout_err(timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
        vec++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errs++; $display("FAIL reset_req got req=%b we=%b want 0/0", mem_req, mem_we); end
        vec++; if (mem_addr !== 12'h000 || mem_wdata !== 8'h00 || rdata_out !== 8'h00) begin errs++; $display("FAIL reset_regs got mar=%h wdr=%h mdr=%h want 0", mem_addr, mem_wdata, rdata_out); end
        vec++; if (overlap_err !== 1'b0 || timeout_err !== 1'b0) begin errs++; $display("FAIL reset_err got ovl=%b tmo=%b want 0/0", overlap_err, timeout_err); end
        vec++; if (bus_drive !== 1'b0) begin errs++; $display("FAIL reset_bus_drive got %b want 0", bus_drive); end
    endtask

    task automatic test_zero_wait_read();
        addr_in = 12'h0A5; mld = 1'b1;
        tick();
        mld = 1'b0;
        vec++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL zw_req got req=%b we=%b busy=%b want 1/0/1", mem_req, mem_we, busy); end
        vec++; if (mem_addr !== 12'h0A5) begin errs++; $display("FAIL zw_addr got %h want 0a5", mem_addr); end
        mem_ack = 1'b1; mem_rdata = 8'h3C; mout = 1'b1;
        #1;
        vec++; if (bus_drive !== 1'b0) begin errs++; $display("FAIL zw_mout_busy got %b want 0", bus_drive); end
        tick();
        mem_ack = 1'b0; mem_rdata = 8'h00;
        vec++; if (busy !== 1'b0 || mem_req !== 1'b0) begin errs++; $display("FAIL zw_done got busy=%b req=%b want 0/0", busy, mem_req); end
        vec++; if (rdata_out !== 8'h3C) begin errs++; $display("FAIL zw_data got %h want 3c", rdata_out); end
        vec++; if (bus_drive !== 1'b1) begin errs++; $display("FAIL zw_bus_drive got %b want 1", bus_drive); end
        vec++; if (overlap_err !== 1'b0) begin errs++; $display("FAIL zw_ovl got %b want 0", overlap_err); end
        mout = 1'b0;
    endtask

    task automatic test_write_3wait();
        addr_in = 12'h7FF; wdata_in = 8'h81; mem_write = 1'b1;
        tick();
        mem_write = 1'b0; wdata_in = 8'h00; addr_in = 12'h000;
        for (int i = 0; i < 4; i++) begin
            vec++; if (busy !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b1) begin errs++; $display("FAIL wr_hold%0d got busy=%b req=%b we=%b want 1/1/1", i, busy, mem_req, mem_we); end
            vec++; if (mem_addr !== 12'h7FF || mem_wdata !== 8'h81) begin errs++; $display("FAIL wr_bus%0d got addr=%h wdata=%h want 7ff/81", i, mem_addr, mem_wdata); end
            if (i == 3) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        vec++; if (busy !== 1'b0 || mem_we !== 1'b0) begin errs++; $display("FAIL wr_done got busy=%b we=%b want 0/0", busy, mem_we); end
        vec++; if (rdata_out !== 8'h3C) begin errs++; $display("FAIL wr_mdr got %h want 3c", rdata_out); end
        vec++; if (mem_addr !== 12'h7FF) begin errs++; $display("FAIL wr_mar_hold got %h want 7ff", mem_addr); end
    endtask

    task automatic test_collision();
        addr_in = 12'h123; wdata_in = 8'h5A; mld = 1'b1; mem_write = 1'b1;
        tick();
        mld = 1'b0; mem_write = 1'b0;
        vec++; if (mem_we !== 1'b1 || mem_addr !== 12'h123 || mem_wdata !== 8'h5A) begin errs++; $display("FAIL col_write got we=%b addr=%h wdata=%h want 1/123/5a", mem_we, mem_addr, mem_wdata); end
        vec++; if (overlap_err !== 1'b1) begin errs++; $display("FAIL col_ovl got %b want 1", overlap_err); end
        addr_in = 12'h456; mld = 1'b1;
        tick();
        mld = 1'b0;
        vec++; if (mem_addr !== 12'h123 || busy !== 1'b1 || mem_we !== 1'b1) begin errs++; $display("FAIL col_ignore got addr=%h busy=%b we=%b want 123/1/1", mem_addr, busy, mem_we); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        vec++; if (busy !== 1'b0 || mem_addr !== 12'h123 || rdata_out !== 8'h3C) begin errs++; $display("FAIL col_done got busy=%b addr=%h mdr=%h want 0/123/3c", busy, mem_addr, rdata_out); end
        vec++; if (overlap_err !== 1'b1) begin errs++; $display("FAIL col_sticky got %b want 1", overlap_err); end
    endtask

    task automatic test_reset_mid_read();
        addr_in = 12'h200; mld = 1'b1;
        tick();
        mld = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vec++; if (mem_req !== 1'b0 || busy !== 1'b0 || rdata_out !== 8'h00) begin errs++; $display("FAIL rst_mid got req=%b busy=%b mdr=%h want 0/0/00", mem_req, busy, rdata_out); end
        vec++; if (overlap_err !== 1'b0 || mem_addr !== 12'h000) begin errs++; $display("FAIL rst_mid_regs got ovl=%b addr=%h want 0/000", overlap_err, mem_addr); end
        addr_in = 12'h010; mld = 1'b1;
        tick();
        mld = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h55;
        tick();
        mem_ack = 1'b0;
        vec++; if (rdata_out !== 8'h55 || busy !== 1'b0 || mem_addr !== 12'h010) begin errs++; $display("FAIL rst_reread got mdr=%h busy=%b addr=%h want 55/0/010", rdata_out, busy, mem_addr); end
    endtask

    task automatic test_back_to_back();
        addr_in = 12'h001; mld = 1'b1;
        tick();
        mld = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h11;
        tick();
        mem_ack = 1'b0;
        vec++; if (rdata_out !== 8'h11 || busy !== 1'b0) begin errs++; $display("FAIL b2b_first got mdr=%h busy=%b want 11/0", rdata_out, busy); end
        addr_in = 12'h002; mld = 1'b1;
        tick();
        mld = 1'b0;
        vec++; if (busy !== 1'b1 || mem_addr !== 12'h002 || mem_req !== 1'b1) begin errs++; $display("FAIL b2b_accept got busy=%b addr=%h req=%b want 1/002/1", busy, mem_addr, mem_req); end
        mem_ack = 1'b1; mem_rdata = 8'h22;
        tick();
        mem_ack = 1'b0;
        vec++; if (rdata_out !== 8'h22 || overlap_err !== 1'b0) begin errs++; $display("FAIL b2b_second got mdr=%h ovl=%b want 22/0", rdata_out, overlap_err); end
    endtask

    task automatic test_ack_idle();
        mem_ack = 1'b1; mem_rdata = 8'h99;
        tick();
        mem_ack = 1'b0;
        vec++; if (rdata_out !== 8'h22 || busy !== 1'b0 || mem_req !== 1'b0) begin errs++; $display("FAIL ack_idle got mdr=%h busy=%b req=%b want 22/0/0", rdata_out, busy, mem_req); end
    endtask

    task automatic test_timeout();
        int n;
`ifdef MEM_TIMEOUT_EN
        addr_in = 12'h300; mld = 1'b1;
        tick();
        mld = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        vec++; if (n !== 15) begin errs++; $display("FAIL to_busy_len got %0d want 15", n); end
        vec++; if (rdata_out !== 8'hFF || timeout_err !== 1'b1) begin errs++; $display("FAIL to_abort got mdr=%h tmo=%b want ff/1", rdata_out, timeout_err); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mld = 1'b1;
        tick();
        mld = 1'b0;
        for (int i = 1; i < 15; i++) tick();
        vec++; if (busy !== 1'b1) begin errs++; $display("FAIL to_cycle15_busy got %b want 1", busy); end
        mem_ack = 1'b1; mem_rdata = 8'h77;
        tick();
        mem_ack = 1'b0;
        vec++; if (rdata_out !== 8'h77 || timeout_err !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL to_ack_wins got mdr=%h tmo=%b busy=%b want 77/0/0", rdata_out, timeout_err, busy); end
`else
        addr_in = 12'h300; mld = 1'b1;
        tick();
        mld = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy === 1'b1) n++;
            tick();
        end
        vec++; if (n !== 20 || timeout_err !== 1'b0) begin errs++; $display("FAIL nowait_forever got busy_cycles=%0d tmo=%b want 20/0", n, timeout_err); end
        mem_ack = 1'b1; mem_rdata = 8'h77;
        tick();
        mem_ack = 1'b0;
        vec++; if (rdata_out !== 8'h77 || busy !== 1'b0) begin errs++; $display("FAIL nowait_ack got mdr=%h busy=%b want 77/0", rdata_out, busy); end
`endif
    endtask

    initial begin
        rst = 1'b1; addr_in = '0; wdata_in = '0; mld = 1'b0; mem_write = 1'b0;
        mout = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
        test_reset();
        test_zero_wait_read();
        test_write_3wait();
        test_collision();
        test_reset_mid_read();
        test_back_to_back();
        test_ack_idle();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
